pre_filter_rr: RTL and testbench
================================

// Module: pre_filter_rr
// PURPOSE
//  Parametrised successor to the two-bank packer write-enable steering block. It drives
//  FIFO write strobes for NUM_BANKS banks in round-robin bursts of a programmable length.
//  Each bank has LANES_PER_BANK parallel FIFOs, all strobed together. Adds full-aware
//  scheduling with stall and skip modes, per-burst status, a drop counter and a sticky
//  overflow flag. Sits between the packer and the bank FIFOs.
// PARAMETERS
//  NUM_BANKS       2    number of FIFO banks served round-robin (2..8)
//  LANES_PER_BANK  2    FIFOs per bank, strobed together
//  LEN_W           13   width of packer_len and of the burst counter
//  DROP_W          16   width of drop_cnt
// PORTS
//  clk        in   1                         clock
//  reset      in   1                         asynchronous, active-high reset
//  ce         in   1                         clock enable; all registers hold when low
//  enable     in   1                         run request; low aborts to IDLE
//  packer_len in   LEN_W                     burst length L in cycles; 0 is treated as 1
//  skip_mode  in   1                         0 = stall on full bank, 1 = skip full bank
//  bank_full  in   NUM_BANKS                 per-bank full flag from the bank FIFOs
//  fifo_wr    out  NUM_BANKS*LANES_PER_BANK  strobe; bit b*LANES_PER_BANK+l = bank b, lane l
//  active_bank out $clog2(NUM_BANKS)         bank owning the current or next burst
//  burst_done out  1                         1-cycle pulse after the last strobe of a burst
//  drop_cnt   out  DROP_W                    skipped bursts; saturates at all-ones
//  ovf_err    out  1                         sticky; bank_full seen high while writing that bank
// BEHAVIOUR
//  Reset: all outputs and registers go to 0 and state is IDLE. Reset is async on assert
//   and sync on release.
//  ce low: every register holds, including the strobes. Everything below is in ce-qualified cycles.
//  All outputs are registered.
//  States: IDLE, CHECK, WRITE, WAIT, SKIP.
//  IDLE: ptr=0, count=0. When enable=1: latch len = max(packer_len,1) -> CHECK.
//  CHECK, 1 cycle with no strobes, target ptr:
//   - bank_full[ptr]=0 -> WRITE.
//   - bank_full[ptr]=1 and skip_mode=0 -> WAIT.
//   - bank_full[ptr]=1 and skip_mode=1 -> SKIP.
//  WRITE: all lanes of bank ptr strobed for exactly len consecutive cycles.
//   - After the last strobe: burst_done pulses, ptr advances (wraps NUM_BANKS-1 -> 0),
//     packer_len is re-latched (takes effect per burst), and the next burst enters WRITE
//     directly with no gap if the next bank is not full; otherwise it goes through CHECK.
//  WAIT: strobes low until bank_full[ptr]=0, then WRITE. burst_done is not pulsed on entry.
//  SKIP: strobes low for len cycles so data alignment is kept. Then drop_cnt+1, burst_done
//   pulses, ptr advances.
//  Only one bank is strobed at a time. Other banks' strobes are always 0.
//  ovf_err is set when bank_full[ptr]=1 is sampled during WRITE. Writing continues (no mid-burst stall).
//  enable=0 in any state: next cycle strobes are 0, state is IDLE, ptr=0, and the burst is
//   abandoned with no burst_done.
//  Latency: enable sampled high at edge k -> CHECK after k+1 -> first strobe visible after edge k+2.
//  Counter: count runs 0..len-1 at LEN_W bits. The compare is count==len-1, so no overflow
//   is possible at len = 2^LEN_W-1.
// STRUCTURE
//  Shared package pre_filter_pkg: state encoding constants and the lane-index function.
//  Sub-module rr_ptr: wrapping bank pointer with an advance input, reusable by the read side.
// TESTING
//  1 NUM_BANKS=2, L=4, no full -> wr[1:0] high 4 cycles, then wr[3:2] high 4 cycles,
//    alternating with no gaps; burst_done every 4 cycles.
//  2 NUM_BANKS=4, L=1 -> each bank strobed 1 cycle in order 0,1,2,3,0.
//  3 skip_mode=1, bank_full[1]=1, L=3 -> bank 1 quiet for 3 cycles, drop_cnt=1, bank 2 next;
//    skip_mode=0 -> stall until bank_full[1] clears.
//  4 enable low mid-burst (L=8, cycle 5) -> strobes 0 next cycle, no burst_done;
//    re-enable restarts at bank 0 with the full length.
//  5 packer_len=0 -> 1-cycle bursts. packer_len changed mid-burst from 4 to 6 -> current
//    burst is 4 cycles, the next is 6.
//  6 bank_full asserted during WRITE -> ovf_err=1 and stays set. reset asserted async
//    mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/pre_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pre_filter_pkg
// Purpose  : Shared definitions for the round-robin bank write steering logic:
//            controller state encoding and the strobe lane-index mapping.
// Revision : 1.0 - initial release
// ============================================================================
package pre_filter_pkg;

   localparam int unsigned c_STATE_W = 3;

   typedef enum logic [c_STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_WRITE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_SKIP  = 3'd4
   } state_t;

   // Position of (bank, lane) inside the flat strobe vector.
   function automatic int unsigned lane_idx(input int unsigned bank,
                                            input int unsigned lane,
                                            input int unsigned lanes_per_bank);
      return bank * lanes_per_bank + lane;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pre_filter_rr_ptr.sv
`default_nettype none
// ============================================================================
// Module   : rr_ptr
// Purpose  : Wrapping round-robin bank pointer. Advances 0..NUM_BANKS-1 and
//            wraps to 0; clear has priority over advance. Also exposes the
//            value the pointer will take on the next advance.
// Ports    : clk_i      clock
//            reset_i    asynchronous active-high reset
//            en_i       clock enable, pointer holds when low
//            clear_i    force pointer to 0
//            advance_i  step to the next bank
//            ptr_o      current bank (registered)
//            ptr_next_o bank following ptr_o
// Revision : 1.0 - initial release
// ============================================================================
module rr_ptr
   import pre_filter_pkg::*;
#(
   parameter int unsigned NUM_BANKS = 2,
   parameter int unsigned PTR_W     = $clog2(NUM_BANKS)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             clear_i,
   input  logic             advance_i,
   output logic [PTR_W-1:0] ptr_o,
   output logic [PTR_W-1:0] ptr_next_o
);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   assign ptr_next_o = (ptr_q == PTR_W'(NUM_BANKS - 1)) ? '0 : ptr_q + PTR_W'(1);
   assign ptr_o      = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (clear_i) begin
         ptr_d = '0;
      end else if (advance_i) begin
         ptr_d = ptr_next_o;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ptr_q <= '0;
      end else if (en_i) begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pre_filter_rr.sv
`default_nettype none
// ============================================================================
// Module   : pre_filter_rr
// Purpose  : Drives FIFO write strobes for NUM_BANKS banks in round-robin
//            bursts of a programmable length. All LANES_PER_BANK FIFOs of the
//            owning bank are strobed together. A full bank either stalls the
//            schedule or has its burst slot skipped (counted in drop_cnt_o).
// Ports    : clk_i          clock
//            reset_i        asynchronous active-high reset
//            ce_i           clock enable, every register holds when low
//            enable_i       run request, low aborts to idle
//            packer_len_i   burst length in cycles (0 behaves as 1)
//            skip_mode_i    0 = stall on a full bank, 1 = skip it
//            bank_full_i    per-bank full flags
//            fifo_wr_o      strobes, bit b*LANES_PER_BANK+l = bank b lane l
//            active_bank_o  bank owning the current or next burst
//            burst_done_o   one-cycle pulse after the last strobe of a burst
//            drop_cnt_o     number of skipped bursts, saturating
//            ovf_err_o      sticky, bank was full while being written
// Revision : 1.0 - initial release
// ============================================================================
module pre_filter_rr
   import pre_filter_pkg::*;
#(
   parameter int unsigned NUM_BANKS      = 2,
   parameter int unsigned LANES_PER_BANK = 2,
   parameter int unsigned LEN_W          = 13,
   parameter int unsigned DROP_W         = 16
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic                                ce_i,
   input  logic                                enable_i,
   input  logic [LEN_W-1:0]                    packer_len_i,
   input  logic                                skip_mode_i,
   input  logic [NUM_BANKS-1:0]                bank_full_i,
   output logic [NUM_BANKS*LANES_PER_BANK-1:0] fifo_wr_o,
   output logic [$clog2(NUM_BANKS)-1:0]        active_bank_o,
   output logic                                burst_done_o,
   output logic [DROP_W-1:0]                   drop_cnt_o,
   output logic                                ovf_err_o
);

   localparam int unsigned c_PTR_W = $clog2(NUM_BANKS);
   localparam int unsigned c_WR_W  = NUM_BANKS * LANES_PER_BANK;

   state_t              state_q, state_d;
   logic                en_q, en_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    count_q, count_d;
   logic [c_WR_W-1:0]   fifo_wr_q, fifo_wr_d;
   logic                burst_done_q, burst_done_d;
   logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
   logic                ovf_err_q, ovf_err_d;

   logic [c_PTR_W-1:0]  w_ptr;
   logic [c_PTR_W-1:0]  w_ptr_next;
   logic                w_ptr_clr;
   logic                w_ptr_adv;
   logic [c_WR_W-1:0]   w_cur_mask;
   logic [c_WR_W-1:0]   w_next_mask;
   logic [LEN_W-1:0]    w_len_in;
   logic                w_full_cur;
   logic                w_full_next;
   logic                w_last;

   rr_ptr #(
      .NUM_BANKS (NUM_BANKS),
      .PTR_W     (c_PTR_W)
   ) u_rr_ptr (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .en_i       (ce_i),
      .clear_i    (w_ptr_clr),
      .advance_i  (w_ptr_adv),
      .ptr_o      (w_ptr),
      .ptr_next_o (w_ptr_next)
   );

   // Strobe patterns for the current bank and for the bank after it; the
   // latter lets a burst hand over to the next bank with no idle cycle.
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      for (genvar l = 0; l < LANES_PER_BANK; l++) begin : g_lane
         localparam int unsigned c_IDX = lane_idx(b, l, LANES_PER_BANK);
         assign w_cur_mask[c_IDX]  = (w_ptr == c_PTR_W'(b));
         assign w_next_mask[c_IDX] = (w_ptr_next == c_PTR_W'(b));
      end
   end

   assign w_len_in    = (packer_len_i == '0) ? LEN_W'(1) : packer_len_i;
   assign w_full_cur  = bank_full_i[w_ptr];
   assign w_full_next = bank_full_i[w_ptr_next];
   // len_q is never 0 outside idle, so len_q-1 cannot wrap and the counter
   // never needs to reach len_q itself.
   assign w_last      = (count_q == len_q - LEN_W'(1));

   always_comb begin
      state_d      = state_q;
      en_d         = enable_i;
      len_d        = len_q;
      count_d      = count_q;
      fifo_wr_d    = '0;
      burst_done_d = 1'b0;
      drop_cnt_d   = drop_cnt_q;
      ovf_err_d    = ovf_err_q;
      w_ptr_clr    = 1'b0;
      w_ptr_adv    = 1'b0;

      if (!enable_i) begin
         // Abort: the running burst is abandoned without a done pulse.
         state_d   = ST_IDLE;
         count_d   = '0;
         w_ptr_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               // Start on the registered copy of enable so the first strobe
               // appears two edges after enable is first sampled high.
               if (en_q) begin
                  len_d   = w_len_in;
                  count_d = '0;
                  state_d = ST_CHECK;
               end
            end
            ST_CHECK: begin
               count_d = '0;
               if (!w_full_cur) begin
                  state_d   = ST_WRITE;
                  fifo_wr_d = w_cur_mask;
               end else if (skip_mode_i) begin
                  state_d = ST_SKIP;
               end else begin
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!w_full_cur) begin
                  state_d   = ST_WRITE;
                  count_d   = '0;
                  fifo_wr_d = w_cur_mask;
               end
            end
            ST_WRITE: begin
               // Full during a write is flagged but never interrupts it.
               if (w_full_cur) begin
                  ovf_err_d = 1'b1;
               end
               if (w_last) begin
                  burst_done_d = 1'b1;
                  w_ptr_adv    = 1'b1;
                  len_d        = w_len_in;
                  count_d      = '0;
                  if (!w_full_next) begin
                     fifo_wr_d = w_next_mask;
                  end else begin
                     state_d = ST_CHECK;
                  end
               end else begin
                  count_d   = count_q + LEN_W'(1);
                  fifo_wr_d = w_cur_mask;
               end
            end
            ST_SKIP: begin
               // Quiet slot of the same length as a burst keeps the other
               // banks' data aligned.
               if (w_last) begin
                  if (drop_cnt_q != '1) begin
                     drop_cnt_d = drop_cnt_q + DROP_W'(1);
                  end
                  burst_done_d = 1'b1;
                  w_ptr_adv    = 1'b1;
                  len_d        = w_len_in;
                  count_d      = '0;
                  state_d      = ST_CHECK;
               end else begin
                  count_d = count_q + LEN_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         en_q         <= 1'b0;
         len_q        <= '0;
         count_q      <= '0;
         fifo_wr_q    <= '0;
         burst_done_q <= 1'b0;
         drop_cnt_q   <= '0;
         ovf_err_q    <= 1'b0;
      end else if (ce_i) begin
         state_q      <= state_d;
         en_q         <= en_d;
         len_q        <= len_d;
         count_q      <= count_d;
         fifo_wr_q    <= fifo_wr_d;
         burst_done_q <= burst_done_d;
         drop_cnt_q   <= drop_cnt_d;
         ovf_err_q    <= ovf_err_d;
      end
   end

   assign fifo_wr_o     = fifo_wr_q;
   assign active_bank_o = w_ptr;
   assign burst_done_o  = burst_done_q;
   assign drop_cnt_o    = drop_cnt_q;
   assign ovf_err_o     = ovf_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pre_filter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_pre_filter_rr
// Purpose  : Self-checking bench. Two instances share the stimulus: A with
//            four banks and default widths, B with two banks, a 4-bit length
//            and a 2-bit drop counter. A behavioural model is compared with
//            both on every cycle, and directed scenarios pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pre_filter_rr;

   localparam int S_IDLE  = 0;
   localparam int S_CHECK = 1;
   localparam int S_WRITE = 2;
   localparam int S_WAIT  = 3;
   localparam int S_SKIP  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0;
   logic        enable = 1'b0;
   logic        skip_mode = 1'b0;
   logic [12:0] packer_len = '0;
   logic [3:0]  bank_full = '0;

   logic [7:0]  wr_a;
   logic [1:0]  ab_a;
   logic        done_a;
   logic [15:0] drop_a;
   logic        ovf_a;
   logic [3:0]  wr_b;
   logic [0:0]  ab_b;
   logic        done_b;
   logic [1:0]  drop_b;
   logic        ovf_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pre_filter_rr #(.NUM_BANKS(4), .LANES_PER_BANK(2), .LEN_W(13), .DROP_W(16)) u_dut_a (
      .clk_i(clk), .reset_i(rst), .ce_i(ce), .enable_i(enable),
      .packer_len_i(packer_len), .skip_mode_i(skip_mode), .bank_full_i(bank_full),
      .fifo_wr_o(wr_a), .active_bank_o(ab_a), .burst_done_o(done_a),
      .drop_cnt_o(drop_a), .ovf_err_o(ovf_a)
   );

   pre_filter_rr #(.NUM_BANKS(2), .LANES_PER_BANK(2), .LEN_W(4), .DROP_W(2)) u_dut_b (
      .clk_i(clk), .reset_i(rst), .ce_i(ce), .enable_i(enable),
      .packer_len_i(packer_len[3:0]), .skip_mode_i(skip_mode), .bank_full_i(bank_full[1:0]),
      .fifo_wr_o(wr_b), .active_bank_o(ab_b), .burst_done_o(done_b),
      .drop_cnt_o(drop_b), .ovf_err_o(ovf_b)
   );

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (index 0 = A, 1 = B) ----------------
   int nbk[2] = '{4, 2};
   int lw[2]  = '{13, 4};
   int dw[2]  = '{16, 2};
   int m_state[2], m_en[2], m_ptr[2], m_len[2], m_left[2];
   int m_wr[2], m_done[2], m_drop[2], m_ovf[2];

   task automatic model_reset(input int i);
      m_state[i] = S_IDLE; m_en[i] = 0; m_ptr[i] = 0; m_len[i] = 0; m_left[i] = 0;
      m_wr[i] = 0; m_done[i] = 0; m_drop[i] = 0; m_ovf[i] = 0;
   endtask

   task automatic model_step(input int i);
      int pl;
      int en_prev;
      int wb;
      if (!ce) return;
      en_prev = m_en[i];
      m_en[i] = int'(enable);
      pl = int'(packer_len) & ((1 << lw[i]) - 1);
      if (pl == 0) pl = 1;
      m_done[i] = 0;
      wb = -1;
      if (!enable) begin
         m_state[i] = S_IDLE;
         m_ptr[i]   = 0;
      end else begin
         case (m_state[i])
            S_IDLE: if (en_prev != 0) begin
               m_len[i] = pl; m_state[i] = S_CHECK;
            end
            S_CHECK: begin
               if (!bank_full[m_ptr[i]]) begin
                  m_state[i] = S_WRITE; m_left[i] = m_len[i]; wb = m_ptr[i];
               end else if (skip_mode) begin
                  m_state[i] = S_SKIP; m_left[i] = m_len[i];
               end else begin
                  m_state[i] = S_WAIT;
               end
            end
            S_WAIT: if (!bank_full[m_ptr[i]]) begin
               m_state[i] = S_WRITE; m_left[i] = m_len[i]; wb = m_ptr[i];
            end
            S_WRITE: begin
               if (bank_full[m_ptr[i]]) m_ovf[i] = 1;
               m_left[i] = m_left[i] - 1;
               if (m_left[i] == 0) begin
                  m_done[i] = 1;
                  m_ptr[i]  = (m_ptr[i] + 1) % nbk[i];
                  m_len[i]  = pl;
                  if (!bank_full[m_ptr[i]]) begin
                     m_left[i] = m_len[i]; wb = m_ptr[i];
                  end else begin
                     m_state[i] = S_CHECK;
                  end
               end else begin
                  wb = m_ptr[i];
               end
            end
            S_SKIP: begin
               m_left[i] = m_left[i] - 1;
               if (m_left[i] == 0) begin
                  if (m_drop[i] < (1 << dw[i]) - 1) m_drop[i] = m_drop[i] + 1;
                  m_done[i]  = 1;
                  m_ptr[i]   = (m_ptr[i] + 1) % nbk[i];
                  m_len[i]   = pl;
                  m_state[i] = S_CHECK;
               end
            end
            default: m_state[i] = S_IDLE;
         endcase
      end
      m_wr[i] = (wb < 0) ? 0 : (3 << (2 * wb));
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0);
         model_step(1);
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if ($time > 2) begin
         chk("m_wr_a",   wr_a,   m_wr[0]);
         chk("m_bank_a", ab_a,   m_ptr[0]);
         chk("m_done_a", done_a, m_done[0]);
         chk("m_drop_a", drop_a, m_drop[0]);
         chk("m_ovf_a",  ovf_a,  m_ovf[0]);
         chk("m_wr_b",   wr_b,   m_wr[1]);
         chk("m_bank_b", ab_b,   m_ptr[1]);
         chk("m_done_b", done_b, m_done[1]);
         chk("m_drop_b", drop_b, m_drop[1]);
         chk("m_ovf_b",  ovf_b,  m_ovf[1]);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Abort, then request a fresh run; returns one negedge after the abort.
   task automatic restart(input int pl);
      enable     = 1'b0;
      packer_len = 13'(pl);
      step(1);
      chk("abort_quiet", wr_a, 0);
      enable = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      #1 rst = 1'b1;
      step(2);
      chk("rst_wr_a", wr_a, 0);
      chk("rst_bank_a", ab_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_drop_a", drop_a, 0);
      chk("rst_ovf_a", ovf_a, 0);
      rst = 1'b0;
      ce  = 1'b1;

      // Equal 4-cycle bursts alternate with no gaps.
      packer_len = 13'd4;
      enable     = 1'b1;
      step(2); chk("s1_check_gap", wr_b, 4'b0000);
      step(1); chk("s1_b0_first", wr_b, 4'b0011);
      chk("s1_b0_nodone", done_b, 0);
      step(3); chk("s1_b0_last", wr_b, 4'b0011);
      step(1); chk("s1_b1_first", wr_b, 4'b1100);
      chk("s1_done", done_b, 1);
      chk("s1_a_bank1", wr_a, 8'h0C);
      step(4); chk("s1_b_wrap", wr_b, 4'b0011);
      chk("s1_a_bank2", wr_a, 8'h30);
      chk("s1_a_ptr", ab_a, 2);

      // Clock enable low freezes everything, strobes included.
      ce = 1'b0;
      step(3); chk("ce_hold_wr", wr_b, 4'b0011);
      chk("ce_hold_done", done_b, 1);
      ce = 1'b1;

      // One-cycle bursts visit every bank in order.
      restart(1);
      step(4); chk("s2_bank1", wr_a, 8'h0C);
      step(2); chk("s2_bank3", wr_a, 8'hC0);
      step(1); chk("s2_wrap0", wr_a, 8'h03);

      // Zero length behaves as one.
      restart(0);
      step(4); chk("s5_len0_b1", wr_b, 4'b1100);
      chk("s5_len0_done", done_b, 1);

      // Length changed mid-burst applies to the following burst.
      restart(4);
      step(4); packer_len = 13'd6;
      step(2); chk("s5_old_len_last", wr_b, 4'b0011);
      step(1); chk("s5_new_first", wr_b, 4'b1100);
      step(5); chk("s5_new_last", wr_b, 4'b1100);
      step(1); chk("s5_next_b0", wr_b, 4'b0011);
      chk("s5_next_done", done_b, 1);

      // Enable dropped in cycle 5 of an 8-cycle burst.
      restart(8);
      step(7); chk("s4_mid", wr_b, 4'b0011);
      enable = 1'b0;
      step(1); chk("s4_abort_wr", wr_b, 0);
      chk("s4_abort_done", done_b, 0);
      chk("s4_abort_ptr", ab_a, 0);
      enable = 1'b1;
      step(3); chk("s4_restart", wr_b, 4'b0011);
      step(7); chk("s4_full_len", wr_b, 4'b0011);
      step(1); chk("s4_next", wr_b, 4'b1100);

      // Largest length representable in B's 4-bit counter.
      restart(15);
      step(17); chk("len_max_last", wr_b, 4'b0011);
      step(1); chk("len_max_next", wr_b, 4'b1100);
      chk("len_max_done", done_b, 1);

      // Skip mode with bank 1 full.
      skip_mode = 1'b1;
      bank_full = 4'b0010;
      restart(3);
      step(6); chk("s3_skip_quiet", wr_a, 0);
      chk("s3_skip_ptr", ab_a, 1);
      step(3); chk("s3_skip_end", wr_a, 0);
      step(1); chk("s3_drop", drop_a, 1);
      chk("s3_skip_done", done_a, 1);
      chk("s3_after_ptr", ab_a, 2);
      step(1); chk("s3_bank2", wr_a, 8'h30);
      step(40); chk("s3_drop_sat", drop_b, 2'b11);

      // Stall mode waits for bank 1 to drain.
      skip_mode = 1'b0;
      restart(3);
      step(9); chk("s3_stall_wr", wr_a, 0);
      chk("s3_stall_ptr", ab_a, 1);
      step(2); bank_full = 4'b0000;
      step(1); chk("s3_resume", wr_a, 8'h0C);
      chk("s3_resume_nodone", done_a, 0);

      // Full seen while writing raises the sticky error; writing goes on.
      bank_full = 4'b0010;
      step(1); chk("s6_ovf", ovf_a, 1);
      chk("s6_keep_writing", wr_a, 8'h0C);
      bank_full = 4'b0000;
      step(2); chk("s6_ovf_sticky", ovf_a, 1);
      chk("s6_next_bank", wr_a, 8'h30);

      // Asynchronous reset mid-burst clears outputs at once.
      #2 rst = 1'b1;
      #1;
      chk("s6_arst_wr", wr_a, 0);
      chk("s6_arst_ovf", ovf_a, 0);
      chk("s6_arst_drop", drop_b, 0);
      chk("s6_arst_wr_b", wr_b, 0);
      step(1);
      rst = 1'b0;
      step(8);
      enable = 1'b0;
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
